// File: rtl/sterownik_wyswietlacza_if.sv
// Display driver bundle: BCD time digits and mode in, segment/digit drive out.
// master = clock/time source side, slave = display driver side.
interface sterownik_wyswietlacza_if;
  logic [3:0] min_jed;
  logic [3:0] min_dzie;
  logic [3:0] godz_jed;
  logic [3:0] godz_dzie;
  logic       start;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output min_jed,
    output min_dzie,
    output godz_jed,
    output godz_dzie,
    output start,
    input  seg,
    input  dp,
    input  an
  );

  modport slave (
    input  min_jed,
    input  min_dzie,
    input  godz_jed,
    input  godz_dzie,
    input  start,
    output seg,
    output dp,
    output an
  );
endinterface

// File: rtl/sterownik_wyswietlacza.sv
// Multiplexed 4-digit 7-segment driver with guard time, colon and set-mode blink.
// Optional LEADING_ZERO_BLANK_EN hides a zero tens-of-hours digit.
module sterownik_wyswietlacza #(
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 16,
  parameter int BLINK_HALF     = 25000000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst_n,
  sterownik_wyswietlacza_if.slave bus
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  localparam logic [6:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic DP_OFF =
    (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [3:0] AN_OFF =
    (DIG_ACTIVE_LOW != 0) ? 4'hf : 4'h0;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BC_LAST  = BW'(BLINK_HALF - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BW-1:0]      bc_q, bc_d;
  logic               phase_q, phase_d;
  logic               start_q, start_d;
  logic [3:0][3:0]    snap_q, snap_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [3:0]         an_q, an_d;

  logic               tick;
  logic [3:0]         digit;
  logic [6:0]         glyph;
  logic               guard;
  logic               blank;
  logic               lzb;
  logic               dp_lit;

  assign tick  = (cnt_q == CNT_LAST);
  assign guard = int'(cnt_q) < GUARD;
  assign digit = snap_q[idx_q];

`ifdef LEADING_ZERO_BLANK_EN
  assign lzb = (idx_q == 2'd3) && (snap_q[3] == 4'd0);
`else
  assign lzb = 1'b0;
`endif

  // Scan prescaler, digit index and per-frame snapshot.
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    idx_d  = idx_q;
    snap_d = snap_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_d[0] = bus.min_jed;
        snap_d[1] = bus.min_dzie;
        snap_d[2] = bus.godz_jed;
        snap_d[3] = bus.godz_dzie;
      end
    end
  end

  // Blink timebase; a mode change restarts it in the lit phase.
  always_comb begin
    start_d = bus.start;
    bc_d    = bc_q + BW'(1);
    phase_d = phase_q;
    if (bus.start != start_q) begin
      bc_d    = '0;
      phase_d = 1'b1;
    end else if (bc_q == BC_LAST) begin
      bc_d    = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    glyph = 7'h40;
    unique case (digit)
      4'd0:    glyph = 7'h3f;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5b;
      4'd3:    glyph = 7'h4f;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6d;
      4'd6:    glyph = 7'h7d;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7f;
      4'd9:    glyph = 7'h6f;
      default: glyph = 7'h40;
    endcase
  end

  always_comb begin
    blank  = guard || lzb || (!start_q && !phase_q);
    dp_lit = (idx_q == 2'd2) && (phase_q || !start_q);
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    an_d   = AN_OFF;
    if (!blank) begin
      seg_d = glyph ^ SEG_OFF;
      dp_d  = dp_lit ^ DP_OFF;
      an_d  = (4'b0001 << idx_q) ^ AN_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      bc_q    <= '0;
      phase_q <= 1'b1;
      start_q <= 1'b0;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      an_q    <= AN_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bc_q    <= bc_d;
      phase_q <= phase_d;
      start_q <= start_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_sterownik_wyswietlacza.sv
// Randomized bench for sterownik_wyswietlacza against a time-based reference model.
// Build with +define+LEADING_ZERO_BLANK_EN to check the blanking variant.
module tb_sterownik_wyswietlacza;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int BH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sterownik_wyswietlacza_if bus();

  sterownik_wyswietlacza #(
    .SCAN_DIV(SD),
    .GUARD(GD),
    .BLINK_HALF(BH),
    .SEG_ACTIVE_LOW(1),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: k = edges since reset release, k0 = edge of last blink restart.
  int         k;
  int         k0;
  logic       msq;
  logic [3:0] msnap [4];

  function automatic logic [6:0] glyph(input logic [3:0] d);
    string s;
    logic [6:0] g;
    case (d)
      4'd0: s = "abcdef";
      4'd1: s = "bc";
      4'd2: s = "abdeg";
      4'd3: s = "abcdg";
      4'd4: s = "bcfg";
      4'd5: s = "acdfg";
      4'd6: s = "acdefg";
      4'd7: s = "abc";
      4'd8: s = "abcdefg";
      4'd9: s = "abcdfg";
      default: s = "g";
    endcase
    g = '0;
    for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    k = 0;
    k0 = 0;
    msq = 1'b0;
    for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
  endtask

  task automatic step();
    int cnt, idx;
    logic ph, off, lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    logic [3:0] smp [4];
    logic s_in;
    cnt = k % SD;
    idx = (k / SD) % 4;
    ph = (((k - k0) / BH) % 2) == 0;
    off = (cnt < GD) || (!msq && !ph);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3 && msnap[3] == 4'd0) off = 1'b1;
`endif
    lit = (idx == 2) && (ph || !msq);
    e_an = 4'hf;
    e_seg = 7'h7f;
    e_dp = 1'b1;
    if (!off) begin
      e_an = ~(4'b0001 << idx);
      e_seg = ~glyph(msnap[idx]);
      e_dp = ~lit;
    end
    smp[0] = bus.min_jed;
    smp[1] = bus.min_dzie;
    smp[2] = bus.godz_jed;
    smp[3] = bus.godz_dzie;
    s_in = bus.start;
    @(posedge clk);
    #1;
    chk("an", 32'(bus.an), 32'(e_an));
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("dp", 32'(bus.dp), 32'(e_dp));
    chk("one_an", 32'($countones(~bus.an) <= 1), 32'd1);
    k++;
    if (s_in != msq) k0 = k;
    msq = s_in;
    if (k % (4 * SD) == 0)
      for (int i = 0; i < 4; i++) msnap[i] = smp[i];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_an"}, 32'(bus.an), 32'hf);
    chk({tag, "_seg"}, 32'(bus.seg), 32'h7f);
    chk({tag, "_dp"}, 32'(bus.dp), 32'd1);
  endtask

  initial begin
    bus.min_jed = 4'd1;
    bus.min_dzie = 4'd2;
    bus.godz_jed = 4'd3;
    bus.godz_dzie = 4'd4;
    bus.start = 1'b1;
    model_reset();
    #12;
    chk_off("reset");
    #5;
    rst_n = 1'b1;
    run(100);

    bus.min_jed = 4'd9;
    run(40);
    for (int i = 0; i < 64 && ((k / SD) % 4) != 1; i++) step();
    chk("reach_idx1", 32'((k / SD) % 4), 32'd1);
    bus.min_jed = 4'd0;
    run(80);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.min_jed = 4'($urandom_range(0, 15));
          1: bus.min_dzie = 4'($urandom_range(0, 15));
          2: bus.godz_jed = 4'($urandom_range(0, 15));
          default: bus.godz_dzie = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 99) == 0) bus.start = ~bus.start;
      step();
    end

    bus.start = 1'b1;
    bus.min_dzie = 4'hc;
    run(80);
    bus.start = 1'b0;
    run(300);
    bus.start = 1'b1;
    run(50);
    bus.start = 1'b0;
    run(20);
    bus.start = 1'b1;
    bus.godz_dzie = 4'd0;
    bus.godz_jed = 4'd8;
    run(100);

    for (int i = 0; i < 16 && (k % SD) != 4; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_off("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_off("hold_rst");
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    run(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
